// File: rtl/cpu_types_pkg.sv
// Shared types for the coherence bus: RAM handshake states, bus FSM states and block geometry.
package cpu_types_pkg;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SNOOP = 3'd1,
      C2C   = 3'd2,
      MEM   = 3'd3,
      WB    = 3'd4
   } bus_state_t;

   localparam int BLKWORDS_DEF = 2;
   localparam int SNOOP_LIMIT  = 64;

endpackage

// File: rtl/coherence_bus_ctrl_if.sv
// Core-side and RAM-side signals of the coherence bus; master drives requests, slave is the controller.
interface coherence_bus_ctrl_if #(parameter int CPUS = 2);

   logic [CPUS-1:0]       iREN, iwait;
   logic [CPUS-1:0][31:0] iaddr;
   logic [31:0]           iload;
   logic [CPUS-1:0]       dREN, dWEN, dwait;
   logic [CPUS-1:0][31:0] daddr, dstore;
   logic [31:0]           dload;
   logic [CPUS-1:0]       cctrans, ccwrite, ccwait, ccinv;
   logic [31:0]           ccsnoopaddr;
   logic                  ramREN, ramWEN;
   logic [31:0]           ramaddr, ramstore, ramload;
   cpu_types_pkg::ramstate_t ramstate;

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
      input  iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
             ramREN, ramWEN, ramaddr, ramstore
   );

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
      output iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
             ramREN, ramWEN, ramaddr, ramstore
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
   parameter int N = 2,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         valid,
   output logic [W-1:0] idx
);

   logic [W-1:0] cand;

   // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      cand  = ptr;
      for (int i = 0; i < N; i++) begin
         if (!valid && req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
         cand = (cand == W'(N-1)) ? '0 : cand + 1'b1;
      end
   end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Snooping coherence bus controller: round-robin data/instruction arbitration, snoop, cache-to-cache and RAM block transfers.
// Optional build macro SNOOP_TIMEOUT_EN adds a 64-cycle snoop timeout and the snoop_err pulse output.
module coherence_bus_ctrl
   import cpu_types_pkg::*;
#(
   parameter int CPUS     = 2,
   parameter int BLKWORDS = BLKWORDS_DEF
) (
   input  logic CLK,
   input  logic nRST,
   coherence_bus_ctrl_if.slave bus
`ifdef SNOOP_TIMEOUT_EN
   ,
   output logic snoop_err
`endif
);

   localparam int IW = (CPUS > 1) ? $clog2(CPUS) : 1;
   localparam int CW = (BLKWORDS > 1) ? $clog2(BLKWORDS) : 1;

   bus_state_t    state, next_state;
   logic [IW-1:0] g, s, drr, irr;
   logic [31:0]   addr_l;
   logic [CW-1:0] cnt;

   logic          d_valid, i_valid;
   logic [IW-1:0] d_idx, i_idx, sup;
   logic          all_ack, any_dirty, beat, last, xfer;

`ifdef SNOOP_TIMEOUT_EN
   logic [5:0] timer;
   logic       timeout;
   assign timeout = (state == SNOOP) && (timer == 6'(SNOOP_LIMIT - 1));
`endif

   function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] x);
      return (x == IW'(CPUS-1)) ? '0 : x + 1'b1;
   endfunction

   rr_arbiter #(.N(CPUS), .W(IW)) u_darb (
      .req   (bus.cctrans | bus.dREN | bus.dWEN),
      .ptr   (drr),
      .valid (d_valid),
      .idx   (d_idx)
   );

   rr_arbiter #(.N(CPUS), .W(IW)) u_iarb (
      .req   (bus.iREN),
      .ptr   (irr),
      .valid (i_valid),
      .idx   (i_idx)
   );

   assign beat = (bus.ramstate == ACCESS);
   assign xfer = (state == C2C) || (state == MEM) || (state == WB);
   assign last = xfer && beat && (cnt == CW'(BLKWORDS - 1));

   // Snoop resolution: every other core must ack; the lowest dirty responder supplies the block.
   always_comb begin
      all_ack   = 1'b1;
      any_dirty = 1'b0;
      sup       = '0;
      for (int j = CPUS - 1; j >= 0; j--) begin
         if (j != int'(g)) begin
            if (!bus.cctrans[j]) all_ack = 1'b0;
            if (bus.ccwrite[j]) begin
               any_dirty = 1'b1;
               sup       = IW'(j);
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state  <= IDLE;
         g      <= '0;
         s      <= '0;
         drr    <= '0;
         irr    <= '0;
         addr_l <= '0;
         cnt    <= '0;
`ifdef SNOOP_TIMEOUT_EN
         timer  <= '0;
`endif
      end else begin
         state <= next_state;
         if (state == IDLE && d_valid) begin
            g      <= d_idx;
            addr_l <= bus.daddr[d_idx];
         end
         if (state == IDLE && !d_valid && i_valid && beat)
            irr <= next_idx(i_idx);
         if (state == SNOOP && all_ack && any_dirty)
            s <= sup;
         if (xfer && beat) begin
            cnt <= last ? '0 : cnt + 1'b1;
            if (last) drr <= next_idx(g);
         end
`ifdef SNOOP_TIMEOUT_EN
         timer <= (state == SNOOP) ? timer + 1'b1 : '0;
`endif
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:
            if (d_valid) begin
               if (bus.cctrans[d_idx])   next_state = SNOOP;
               else if (bus.dWEN[d_idx]) next_state = WB;
               else                      next_state = MEM;
            end
         SNOOP:
            if (all_ack)
               next_state = any_dirty ? C2C : MEM;
`ifdef SNOOP_TIMEOUT_EN
            else if (timeout)
               next_state = MEM;
`endif
         C2C, MEM, WB:
            if (last) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      bus.iwait       = '1;
      bus.dwait       = '1;
      bus.iload       = '0;
      bus.dload       = '0;
      bus.ccwait      = '0;
      bus.ccinv       = '0;
      bus.ccsnoopaddr = '0;
      bus.ramREN      = 1'b0;
      bus.ramWEN      = 1'b0;
      bus.ramaddr     = '0;
      bus.ramstore    = '0;
`ifdef SNOOP_TIMEOUT_EN
      snoop_err       = 1'b0;
`endif
      // Outputs are forced to their reset values for as long as nRST is held low.
      if (nRST) begin
         case (state)
            IDLE:
               if (!d_valid && i_valid) begin
                  bus.ramREN  = 1'b1;
                  bus.ramaddr = bus.iaddr[i_idx];
                  bus.iload   = bus.ramload;
                  if (beat) bus.iwait[i_idx] = 1'b0;
               end
            SNOOP: begin
               for (int j = 0; j < CPUS; j++)
                  if (j != int'(g)) begin
                     bus.ccwait[j] = 1'b1;
                     bus.ccinv[j]  = bus.ccwrite[g];
                  end
               bus.ccsnoopaddr = addr_l;
`ifdef SNOOP_TIMEOUT_EN
               snoop_err = timeout && !all_ack;
`endif
            end
            C2C: begin
               for (int j = 0; j < CPUS; j++)
                  if (j != int'(g)) bus.ccwait[j] = 1'b1;
               bus.ccsnoopaddr = addr_l;
               bus.ramWEN      = 1'b1;
               bus.ramaddr     = bus.daddr[s];
               bus.ramstore    = bus.dstore[s];
               bus.dload       = bus.dstore[s];
               if (beat) begin
                  bus.dwait[g] = 1'b0;
                  bus.dwait[s] = 1'b0;
               end
            end
            MEM: begin
               bus.ramREN  = 1'b1;
               bus.ramaddr = bus.daddr[g];
               bus.dload   = bus.ramload;
               if (beat) bus.dwait[g] = 1'b0;
            end
            WB: begin
               bus.ramWEN   = 1'b1;
               bus.ramaddr  = bus.daddr[g];
               bus.ramstore = bus.dstore[g];
               if (beat) bus.dwait[g] = 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl (CPUS=2, BLKWORDS=2); define SNOOP_TIMEOUT_EN to exercise the snoop timeout.
module tb_coherence_bus_ctrl;
   import cpu_types_pkg::*;

   logic CLK = 1'b0;
   logic nRST;
   int   n_cmp = 0;
   int   n_err = 0;

`ifdef SNOOP_TIMEOUT_EN
   logic snoop_err;
`endif

   always #5 CLK = ~CLK;

   coherence_bus_ctrl_if #(.CPUS(2)) bus ();

   coherence_bus_ctrl #(.CPUS(2), .BLKWORDS(2)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus.slave)
`ifdef SNOOP_TIMEOUT_EN
      ,
      .snoop_err (snoop_err)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_data();
      bus.dREN    = '0;
      bus.dWEN    = '0;
      bus.cctrans = '0;
      bus.ccwrite = '0;
   endtask

   initial begin
      nRST         = 1'b0;
      clear_data();
      bus.daddr    = '0;
      bus.dstore   = '0;
      bus.iREN     = 2'b11;
      bus.iaddr[0] = 32'h1000;
      bus.iaddr[1] = 32'h2000;
      bus.ramload  = 32'hAAAA;
      bus.ramstate = ACCESS;
      #2;
      check("rst_iwait",  32'(bus.iwait),  32'h3);
      check("rst_dwait",  32'(bus.dwait),  32'h3);
      check("rst_ccwait", 32'(bus.ccwait), 32'h0);
      check("rst_ccinv",  32'(bus.ccinv),  32'h0);
      check("rst_ramREN", 32'(bus.ramREN), 32'h0);
      check("rst_ramWEN", 32'(bus.ramWEN), 32'h0);
      check("rst_ramaddr", bus.ramaddr,    32'h0);

      // Instruction fetch alternates between cores; BUSY holds the grant.
      step();
      nRST = 1'b1;
      #1;
      check("i0_addr",  bus.ramaddr,          32'h1000);
      check("i0_iwait", 32'(bus.iwait),       32'h2);
      check("i0_iload", bus.iload,            32'hAAAA);
      step();
      check("i1_addr",  bus.ramaddr,          32'h2000);
      check("i1_iwait", 32'(bus.iwait),       32'h1);
      step();
      check("i2_addr",  bus.ramaddr,          32'h1000);
      bus.ramstate = BUSY;
      #1;
      check("ibusy_iwait",  32'(bus.iwait),   32'h3);
      check("ibusy_ramREN", 32'(bus.ramREN),  32'h1);
      step();
      check("ibusy_hold", bus.ramaddr,        32'h1000);
      bus.ramstate = ACCESS;
      #1;
      check("i3_iwait", 32'(bus.iwait),       32'h2);
      step();
      bus.iREN = '0;

      // Simultaneous reads: core0 first, then core1, each a 2-beat MEM block.
      bus.dREN     = 2'b11;
      bus.daddr[0] = 32'h100;
      bus.daddr[1] = 32'h200;
      bus.ramload  = 32'h1111;
      #1;
      check("d_idle_ramREN", 32'(bus.ramREN), 32'h0);
      check("d_idle_dwait",  32'(bus.dwait),  32'h3);
      step();
      check("d0_addr",  bus.ramaddr,          32'h100);
      check("d0_dwait", 32'(bus.dwait),       32'h2);
      check("d0_dload", bus.dload,            32'h1111);
      step();
      check("d0_beat2", bus.ramaddr,          32'h100);
      step();
      check("d_gap_ramREN", 32'(bus.ramREN),  32'h0);
      step();
      check("d1_addr",  bus.ramaddr,          32'h200);
      check("d1_dwait", 32'(bus.dwait),       32'h1);
      step();
      bus.dREN = '0;
      #1;
      check("d1_beat2", 32'(bus.dwait),       32'h1);
      step();
      check("d_end_ramREN", 32'(bus.ramREN),  32'h0);

      // core0 BusRd, core1 acks clean -> MEM.
      bus.cctrans  = 2'b01;
      bus.dREN     = 2'b01;
      bus.daddr[0] = 32'h300;
      step();
      check("rd_ccwait", 32'(bus.ccwait),     32'h2);
      check("rd_snaddr", bus.ccsnoopaddr,     32'h300);
      check("rd_ccinv",  32'(bus.ccinv),      32'h0);
      check("rd_ramREN", 32'(bus.ramREN),     32'h0);
      step();
      bus.cctrans = 2'b11;
      #1;
      check("rd_hold_ccwait", 32'(bus.ccwait), 32'h2);
      step();
      check("rd_mem_ramREN", 32'(bus.ramREN), 32'h1);
      check("rd_mem_addr",   bus.ramaddr,     32'h300);
      check("rd_mem_ccinv",  32'(bus.ccinv),  32'h0);
      check("rd_mem_ccwait", 32'(bus.ccwait), 32'h0);
      clear_data();
      step();
      step();
      check("rd_end_ramREN", 32'(bus.ramREN), 32'h0);

      // core1 BusRdX, core0 supplies dirty block -> C2C.
      bus.cctrans  = 2'b10;
      bus.dREN     = 2'b10;
      bus.ccwrite  = 2'b10;
      bus.daddr[1] = 32'h40;
      step();
      check("x_ccwait", 32'(bus.ccwait),      32'h1);
      check("x_ccinv",  32'(bus.ccinv),       32'h1);
      check("x_snaddr", bus.ccsnoopaddr,      32'h40);
      bus.cctrans   = 2'b11;
      bus.ccwrite   = 2'b11;
      bus.daddr[0]  = 32'h40;
      bus.dstore[0] = 32'hDEAD;
      step();
      check("c2c_ramWEN", 32'(bus.ramWEN),    32'h1);
      check("c2c_addr",   bus.ramaddr,        32'h40);
      check("c2c_store",  bus.ramstore,       32'hDEAD);
      check("c2c_dload",  bus.dload,          32'hDEAD);
      check("c2c_dwait",  32'(bus.dwait),     32'h0);
      check("c2c_ccwait", 32'(bus.ccwait),    32'h1);
      step();
      bus.daddr[0]  = 32'h44;
      bus.dstore[0] = 32'hBEEF;
      #1;
      check("c2c_b2_addr",  bus.ramaddr,      32'h44);
      check("c2c_b2_dload", bus.dload,        32'hBEEF);
      clear_data();
      step();
      check("c2c_end_ccwait", 32'(bus.ccwait), 32'h0);
      check("c2c_end_ramWEN", 32'(bus.ramWEN), 32'h0);

`ifdef SNOOP_TIMEOUT_EN
      // Unanswered snoop times out into MEM after 64 cycles.
      bus.cctrans  = 2'b01;
      bus.dREN     = 2'b01;
      bus.daddr[0] = 32'h500;
      step();
      repeat (62) step();
      check("to_no_err", 32'(snoop_err),      32'h0);
      step();
      check("to_err",    32'(snoop_err),      32'h1);
      step();
      check("to_mem_ramREN", 32'(bus.ramREN), 32'h1);
      check("to_mem_addr",   bus.ramaddr,     32'h500);
      check("to_err_pulse",  32'(snoop_err),  32'h0);
      clear_data();
      step();
      step();
`endif

      // Reset during the first C2C beat abandons the transfer.
      bus.cctrans  = 2'b10;
      bus.dREN     = 2'b10;
      bus.ccwrite  = 2'b10;
      bus.daddr[1] = 32'h80;
      step();
      bus.cctrans   = 2'b11;
      bus.ccwrite   = 2'b11;
      bus.daddr[0]  = 32'h80;
      bus.dstore[0] = 32'hCAFE;
      step();
      check("rst_c2c_ramWEN", 32'(bus.ramWEN), 32'h1);
      nRST = 1'b0;
      #1;
      check("rmid_dwait",  32'(bus.dwait),    32'h3);
      check("rmid_iwait",  32'(bus.iwait),    32'h3);
      check("rmid_ccwait", 32'(bus.ccwait),   32'h0);
      check("rmid_ramWEN", 32'(bus.ramWEN),   32'h0);
      clear_data();
      step();
      nRST     = 1'b1;
      bus.iREN = 2'b11;
      #1;
      check("post_rst_iaddr",  bus.ramaddr,    32'h1000);
      check("post_rst_ccwait", 32'(bus.ccwait), 32'h0);
      bus.iREN     = '0;
      bus.dREN     = 2'b11;
      bus.daddr[0] = 32'h100;
      bus.daddr[1] = 32'h200;
      step();
      check("post_rst_daddr", bus.ramaddr,    32'h100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
